// File: rtl/hex_scan_controller_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan controller.
package hex_scan_controller_pkg;

  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam int unsigned BCD_W     = 4;
  localparam logic [3:0]  BCD_MAX   = 4'd9;

  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/hex_scan_controller_if.sv
// Valid/ready load port carrying one BCD value per digit.
interface hex_scan_controller_if
  import hex_scan_controller_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
);

  logic                          load_valid;
  logic                          load_ready;
  logic [BCD_W*NUM_DIGITS-1:0]   load_data;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );

endinterface

// File: rtl/hex_display.sv
// Hex digit to active-low 7-segment decoder (bit 0 = segment a).
module hex_display (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (digit)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/hex_scan_controller.sv
// Scans NUM_DIGITS BCD digits onto a shared decoder with frame-aligned double buffering,
// leading-zero blanking and a sticky invalid-digit flag.
module hex_scan_controller
  import hex_scan_controller_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned PRESCALE      = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hex_scan_controller_if.slave  load,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [6:0]            seg,
  output logic                  frame_done,
  output logic                  digit_err
);

  localparam int unsigned SlotW  = $clog2(PRESCALE);
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned DataW  = BCD_W * NUM_DIGITS;
  localparam logic [SlotW-1:0] SlotLast = SlotW'(PRESCALE - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_DIGITS - 1);

  logic [SlotW-1:0]      slot_q;
  logic [IdxW-1:0]       idx_q;
  logic [DataW-1:0]      active_q;
  logic [DataW-1:0]      pending_q;
  logic                  pend_full_q;
  logic [NUM_DIGITS-1:0] an_n_q;
  logic [6:0]            seg_q;
  logic                  frame_done_q;
  logic                  err_q;

  logic                  slot_wrap;
  logic                  frame_wrap;
  logic                  accept;
  logic                  apply;
  logic                  guard;
  logic [BCD_W-1:0]      digit_cur;
  logic [6:0]            seg_raw;
  logic [6:0]            seg_drive;
  logic                  drive_invalid;
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  zero_run;

  assign slot_wrap  = (slot_q == SlotLast);
  assign frame_wrap = slot_wrap && (idx_q == IdxLast);
  assign accept     = load.load_valid && !pend_full_q;
  assign apply      = frame_wrap && pend_full_q;
  assign guard      = (slot_q == '0);

  assign load.load_ready = !pend_full_q;

  assign digit_cur = active_q[BCD_W*int'(idx_q) +: BCD_W];

  // A digit is blanked when it and every more significant digit are zero; digit 0 never is.
  always_comb begin
    blank_vec = '0;
    zero_run  = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_run     = zero_run && (active_q[BCD_W*i +: BCD_W] == '0);
      blank_vec[i] = BLANK_LEADING && zero_run && (i != 0);
    end
  end

  hex_display u_hex_display (
    .digit (digit_cur),
    .seg   (seg_raw)
  );

  always_comb begin
    seg_drive     = seg_raw;
    drive_invalid = 1'b0;
    if (!is_bcd(digit_cur)) begin
      seg_drive     = SEG_BLANK;
      drive_invalid = !guard;
    end else if (blank_vec[idx_q]) begin
      seg_drive = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pend_full_q  <= 1'b0;
      an_n_q       <= '1;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      slot_q <= slot_wrap ? '0 : slot_q + SlotW'(1);
      if (slot_wrap) begin
        idx_q <= (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
      end
      if (accept) begin
        pending_q <= load.load_data;
      end
      // Apply reads the old pending contents even if a new transfer lands on the same edge.
      if (apply) begin
        active_q <= pending_q;
      end
      pend_full_q  <= accept || (pend_full_q && !apply);
      an_n_q       <= guard ? '1 : ~(NUM_DIGITS'(1) << idx_q);
      seg_q        <= guard ? SEG_BLANK : seg_drive;
      frame_done_q <= frame_wrap;
      if (apply) begin
        err_q <= 1'b0;
      end else if (drive_invalid) begin
        err_q <= 1'b1;
      end
    end
  end

  assign an_n       = an_n_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;
  assign digit_err  = err_q;

endmodule

// File: tb/tb_hex_scan_controller.sv
// Directed bench for hex_scan_controller with NUM_DIGITS = 4, PRESCALE = 4.
module tb_hex_scan_controller;

  logic       clk;
  logic       rst_n;
  logic [3:0] an_n;
  logic [6:0] seg;
  logic       frame_done;
  logic       digit_err;

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] offers[$];

  // Expected segments per frame, packed {digit3, digit2, digit1, digit0}.
  localparam logic [27:0] TZero = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [27:0] T1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] T0050 = {7'h7F, 7'h7F, 7'h12, 7'h40};
  localparam logic [27:0] T1111 = {7'h79, 7'h79, 7'h79, 7'h79};
  localparam logic [27:0] T2222 = {7'h24, 7'h24, 7'h24, 7'h24};
  localparam logic [27:0] T00A3 = {7'h7F, 7'h7F, 7'h7F, 7'h30};
  localparam logic [27:0] T0003 = {7'h7F, 7'h7F, 7'h7F, 7'h30};

  hex_scan_controller_if #(.NUM_DIGITS(4)) lif ();

  hex_scan_controller #(
    .NUM_DIGITS    (4),
    .PRESCALE      (4),
    .BLANK_LEADING (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (lif.slave),
    .an_n       (an_n),
    .seg        (seg),
    .frame_done (frame_done),
    .digit_err  (digit_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Offers the queue head, advances one clock and samples 1 time unit after the edge.
  task automatic tick();
    logic acc;
    lif.load_valid = (offers.size() > 0);
    lif.load_data  = (offers.size() > 0) ? offers[0] : 16'h0;
    acc = lif.load_valid && lif.load_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      void'(offers.pop_front());
      check_eq("ready_drop", {31'd0, lif.load_ready}, 32'd0);
    end
    lif.load_valid = (offers.size() > 0);
  endtask

  // Runs from a frame start; j = 4*digit + slot of the state that produced each sample.
  task automatic run_frame(input logic [27:0] tbl, input int push_at, input int nvals,
                           input logic [15:0] v1, input logic [15:0] v2,
                           input int nticks, input logic err14);
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int         slot;
    int         d;
    for (int j = 0; j < nticks; j++) begin
      if (j == push_at) begin
        offers.push_back(v1);
        if (nvals > 1) offers.push_back(v2);
      end
      tick();
      slot = j % 4;
      d    = j / 4;
      exp_an  = (slot == 0) ? 4'hF : ~(4'b0001 << d);
      exp_seg = (slot == 0) ? 7'h7F : tbl[7*d +: 7];
      check_eq("an_n", {28'd0, an_n}, {28'd0, exp_an});
      check_eq("seg", {25'd0, seg}, {25'd0, exp_seg});
      check_eq("frame_done", {31'd0, frame_done}, {31'd0, (j == 15)});
      if (j == 14) check_eq("digit_err", {31'd0, digit_err}, {31'd0, err14});
    end
  endtask

  initial begin
    rst_n          = 1'b1;
    lif.load_valid = 1'b0;
    lif.load_data  = 16'h0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_an_n", {28'd0, an_n}, 32'hF);
    check_eq("rst_seg", {25'd0, seg}, 32'h7F);
    check_eq("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check_eq("rst_digit_err", {31'd0, digit_err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("rst_ready", {31'd0, lif.load_ready}, 32'd1);

    run_frame(TZero, -1, 0, 16'h0, 16'h0, 16, 1'b0);
    run_frame(TZero, 5, 1, 16'h1234, 16'h0, 16, 1'b0);
    check_eq("ready_after_apply", {31'd0, lif.load_ready}, 32'd1);
    run_frame(T1234, 2, 1, 16'h0050, 16'h0, 16, 1'b0);
    run_frame(T0050, 3, 2, 16'h1111, 16'h2222, 16, 1'b0);
    run_frame(T1111, -1, 0, 16'h0, 16'h0, 16, 1'b0);
    check_eq("ready_after_b2b", {31'd0, lif.load_ready}, 32'd1);
    run_frame(T2222, 0, 1, 16'h00A3, 16'h0, 16, 1'b0);
    run_frame(T00A3, 8, 1, 16'h0003, 16'h0, 16, 1'b1);
    check_eq("err_cleared_by_apply", {31'd0, digit_err}, 32'd0);
    run_frame(T0003, 0, 1, 16'h00A3, 16'h0, 16, 1'b0);
    check_eq("err_after_valid_frame", {31'd0, digit_err}, 32'd0);

    // Partial frame: error sets on the digit 1 slot, then 16'h9999 is left pending.
    run_frame(T00A3, 6, 1, 16'h9999, 16'h0, 10, 1'b0);
    check_eq("err_set_invalid", {31'd0, digit_err}, 32'd1);
    check_eq("pending_full", {31'd0, lif.load_ready}, 32'd0);

    #2 rst_n = 1'b0;
    #1;
    offers.delete();
    lif.load_valid = 1'b0;
    check_eq("mid_rst_an_n", {28'd0, an_n}, 32'hF);
    check_eq("mid_rst_seg", {25'd0, seg}, 32'h7F);
    check_eq("mid_rst_frame_done", {31'd0, frame_done}, 32'd0);
    check_eq("mid_rst_digit_err", {31'd0, digit_err}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, lif.load_ready}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Two frames past the apply point: the discarded 16'h9999 must never appear.
    run_frame(TZero, -1, 0, 16'h0, 16'h0, 16, 1'b0);
    run_frame(TZero, -1, 0, 16'h0, 16'h0, 16, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_scan_controller.md
Name: hex_scan_controller

Overview:
- Time-multiplexes NUM_DIGITS BCD digits onto one shared hex_display decoder instance and a common-segment, multi-anode 7-segment bank.
- Accepts new display values through a valid/ready handshake, double-buffered so that an update only takes effect at a frame boundary (no tearing).
- Provides leading-zero blanking and sticky invalid-BCD detection.
- Sits between counter/datapath logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; must be at least 2.
- PRESCALE, 50000, clock cycles per digit slot; must be at least 2.
- BLANK_LEADING, 1, 1 enables leading-zero blanking; 0 displays every digit.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- load_valid  input  1  load_data is offered
- load_ready  output  1  pending buffer empty; a transfer occurs when load_valid and load_ready are both 1 on a rising edge
- load_data  input  4*NUM_DIGITS  BCD digits; bits [3:0] are digit 0 (least significant)
- an_n  output  NUM_DIGITS  active-low anode selects; one-hot-low or all 1
- seg  output  7  active-low segments a..g (bit 0 = a), as produced by hex_display
- frame_done  output  1  one-cycle pulse at the end of each full scan
- digit_err  output  1  sticky flag; a digit code of 10..15 was displayed

Behaviour:
- Reset (asynchronous, on rst_n low):
  - slot count = 0, index = 0, active register = 0, pending empty.
  - an_n all 1, seg = 7'h7F, frame_done = 0, digit_err = 0.
  - load_ready = 1 one cycle after reset deasserts.
- Reset mid-frame: all state drops immediately; any pending, unapplied data is discarded.
- Slot counter: counts 0..PRESCALE-1 and wraps.
  - On wrap, index increments; index wraps from NUM_DIGITS-1 to 0.
  - On the cycle the index wraps to 0, frame_done pulses for exactly 1 cycle.
- Guard cycle: while the slot count is 0, an_n is all 1 (ghosting guard).
- Drive phase: while the slot count is 1..PRESCALE-1, an_n[index] = 0 and seg = the decoded pattern for digit[index].
- an_n, seg and frame_done are registered: each shows the state of the previous cycle (1-cycle latency).
- Handshake:
  - load_ready = !pending_full.
  - On an accepted transfer, pending <= load_data and pending_full <= 1.
  - load_data is ignored when load_ready = 0; the source must hold valid until accepted.
- Apply point: in the cycle index wraps to 0, if pending_full then active <= pending and pending_full <= 0. The new value is visible from slot 0 of the next frame.
- Simultaneous transfer and apply in the same cycle:
  - The apply uses the old pending contents.
  - The accepted data is written into pending and stays full.
  - No data is lost or duplicated.
- Leading-zero blanking (BLANK_LEADING = 1):
  - Digit i is blanked (seg = 7'h7F, anode still driven) if digit i and every higher digit are 0.
  - Digit 0 is never blanked, so value 0 displays "0".
- Invalid digit (code 10..15):
  - seg is forced to 7'h7F.
  - digit_err is set when such a digit is driven, and is cleared only by reset or by the next apply.
  - If an apply and an invalid drive occur in the same cycle, the apply clear wins; the error re-sets on that digit's next slot if still invalid.
- Arithmetic: the slot counter is $clog2(PRESCALE) bits wide and the index is $clog2(NUM_DIGITS) bits wide. Neither ever exceeds its terminal value.

Decomposition:
- Shared package constants:
  - SEG_BLANK = 7'h7F
  - BCD_W = 4
  - BCD_MAX = 9
- Sub-module: exactly one instance of the existing hex_display decoder, fed the muxed digit. The invalid-code override and blanking mux sit after it, inside this block.
- No other sub-modules.

Test Plan (bench uses NUM_DIGITS = 4, PRESCALE = 4):
- Reset release with no load -> an_n cycles 1110/1101/1011/0111 with an all-1 guard cycle per slot; digit 0 shows "0" (seg 7'h40); digits 1-3 show 7'h7F; frame_done pulses every 16 cycles.
- Load 16'h1234 mid-frame -> load_ready drops the next cycle; current frame unchanged; next frame shows 4,3,2,1 on digits 0..3; load_ready returns 1 at the apply cycle.
- Load 16'h0050 -> digits 3 and 2 blanked (7'h7F), digit 1 shows "5", digit 0 shows "0".
- Two back-to-back loads 16'h1111 then 16'h2222 in one frame -> the second stalls (load_ready = 0) until the apply; frames show 1111 then 2222; nothing is dropped.
- Load 16'h00A3 -> digit 1 slot drives seg 7'h7F and digit_err sets; a subsequent load of 16'h0003 clears digit_err at its apply.
- Assert rst_n low mid-slot with pending full -> outputs reach reset values immediately; the pending value is never displayed.
